// File: rtl/pc_redirect_if.sv
// Redirect and fetch-PC bundle between execute/fetch (master) and the PC
// redirect controller (slave).
interface pc_redirect_if #(
  parameter int CNT_W = 16
) ();
  logic             redir_valid;
  logic [31:0]      redir_target;
  logic             redir_is_jalr;
  logic             redir_ready;
  logic             fetch_ready;
  logic [31:0]      pc;
  logic             flush;
  logic             misalign_exc;
  logic [31:0]      misalign_addr;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output redir_valid, redir_target, redir_is_jalr, fetch_ready,
    input  redir_ready, pc, flush, misalign_exc, misalign_addr, redirect_cnt
  );

  modport slave (
    input  redir_valid, redir_target, redir_is_jalr, fetch_ready,
    output redir_ready, pc, flush, misalign_exc, misalign_addr, redirect_cnt
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Architectural fetch PC owner: accepts execute redirects, checks alignment,
// reloads the PC and holds flush for FLUSH_CYCLES cycles.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst,
  pc_redirect_if.slave  bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             flush_q, flush_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             exc_q, exc_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             ready;
  logic [31:0]      tgt;

  // JALR targets come from rs1 + imm and must have bit 0 cleared.
  assign tgt = bus.redir_is_jalr ? {bus.redir_target[31:1], 1'b0} : bus.redir_target;

  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    fcnt_d  = fcnt_q;
    exc_d   = 1'b0;
    addr_d  = addr_q;
    rcnt_d  = rcnt_q;
    ready   = 1'b0;

    case (state_q)
      RUN: begin
        ready = 1'b1;
        if (bus.redir_valid) begin
          if (tgt[1:0] != 2'b00) begin
            exc_d  = 1'b1;
            addr_d = tgt;
          end else begin
            pc_d    = tgt;
            flush_d = 1'b1;
            fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
            rcnt_d  = rcnt_q + 1'b1;
            state_d = FLUSH;
          end
        end else if (bus.fetch_ready) begin
          pc_d = pc_q + 32'd4;
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) begin
          flush_d = 1'b0;
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      fcnt_q  <= '0;
      exc_q   <= 1'b0;
      addr_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      fcnt_q  <= fcnt_d;
      exc_q   <= exc_d;
      addr_q  <= addr_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign bus.redir_ready   = ready;
  assign bus.pc            = pc_q;
  assign bus.flush         = flush_q;
  assign bus.misalign_exc  = exc_q;
  assign bus.misalign_addr = addr_q;
  assign bus.redirect_cnt  = rcnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: cycle-level reference model plus
// directed scenarios with literal expectations, and a narrow-counter wrap run.
module tb_pc_redirect_ctrl;

  localparam int FLUSH_N = 2;

  logic clk;
  logic rst;
  logic rst8;
  int   checks;
  int   failures;

  pc_redirect_if #(.CNT_W(16)) bus ();
  pc_redirect_if #(.CNT_W(8))  bus8 ();

  pc_redirect_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .FLUSH_CYCLES(FLUSH_N),
    .CNT_W       (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  pc_redirect_ctrl #(
    .RESET_PC    (32'h0000_0100),
    .FLUSH_CYCLES(1),
    .CNT_W       (8)
  ) dut8 (
    .clk(clk),
    .rst(rst8),
    .bus(bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining flush cycles, PC and event bookkeeping.
  logic        m_on;
  logic [31:0] m_pc;
  int          m_left;
  logic [15:0] m_cnt;
  logic        m_exc;
  logic [31:0] m_addr;
  logic [31:0] m_tgt;

  initial m_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_on   = 1'b1;
      m_pc   = 32'h0;
      m_left = 0;
      m_cnt  = 16'h0;
      m_exc  = 1'b0;
      m_addr = 32'h0;
    end else if (m_on) begin
      m_tgt = bus.redir_is_jalr ? (bus.redir_target & 32'hFFFF_FFFE) : bus.redir_target;
      m_exc = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
      end else if (bus.redir_valid) begin
        if (m_tgt % 4 != 0) begin
          m_exc  = 1'b1;
          m_addr = m_tgt;
        end else begin
          m_pc   = m_tgt;
          m_left = FLUSH_N;
          m_cnt  = m_cnt + 16'd1;
        end
      end else if (bus.fetch_ready) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("model_pc",    bus.pc,            m_pc);
      check("model_flush", 32'(bus.flush),    32'(m_left > 0));
      check("model_ready", 32'(bus.redir_ready), 32'(m_left == 0));
      check("model_exc",   32'(bus.misalign_exc), 32'(m_exc));
      check("model_addr",  bus.misalign_addr, m_addr);
      check("model_cnt",   32'(bus.redirect_cnt), 32'(m_cnt));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    rst8 = 1'b1;
    bus.redir_valid    = 1'b0;
    bus.redir_target   = 32'h0;
    bus.redir_is_jalr  = 1'b0;
    bus.fetch_ready    = 1'b0;
    bus8.redir_valid   = 1'b1;
    bus8.redir_target  = 32'h0000_0200;
    bus8.redir_is_jalr = 1'b0;
    bus8.fetch_ready   = 1'b0;

    // Reset state and sequential fetch
    step(2);
    rst = 1'b0;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_flush", 32'(bus.flush), 32'h0);
    check("rst_ready", 32'(bus.redir_ready), 32'h1);
    check("rst_cnt", 32'(bus.redirect_cnt), 32'h0);
    check("rst_addr", bus.misalign_addr, 32'h0);
    bus.fetch_ready = 1'b1;
    step(1); check("seq_pc4", bus.pc, 32'h4);
    step(1); check("seq_pc8", bus.pc, 32'h8);
    step(1); check("seq_pcC", bus.pc, 32'hC);
    check("seq_flush", 32'(bus.flush), 32'h0);
    step(61); check("seq_pc100", bus.pc, 32'h100);

    // Redirect wins over fetch_ready; flush for two cycles
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h2000;
    step(1);
    bus.redir_valid = 1'b0;
    check("redir_pc", bus.pc, 32'h2000);
    check("redir_flush1", 32'(bus.flush), 32'h1);
    check("redir_ready1", 32'(bus.redir_ready), 32'h0);
    check("redir_cnt", 32'(bus.redirect_cnt), 32'h1);
    step(1);
    check("redir_flush2", 32'(bus.flush), 32'h1);
    check("redir_ready2", 32'(bus.redir_ready), 32'h0);
    check("redir_hold_pc", bus.pc, 32'h2000);
    step(1);
    check("redir_flush_end", 32'(bus.flush), 32'h0);
    check("redir_ready_end", 32'(bus.redir_ready), 32'h1);
    check("redir_pc_end", bus.pc, 32'h2000);
    bus.fetch_ready = 1'b0;

    // JALR bit-0 clear
    bus.redir_valid   = 1'b1;
    bus.redir_target  = 32'h3001;
    bus.redir_is_jalr = 1'b1;
    step(1);
    bus.redir_valid   = 1'b0;
    bus.redir_is_jalr = 1'b0;
    check("jalr_pc", bus.pc, 32'h3000);
    check("jalr_exc", 32'(bus.misalign_exc), 32'h0);
    check("jalr_cnt", 32'(bus.redirect_cnt), 32'h2);
    step(2);

    // Misaligned targets, back to back
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h3002;
    step(1);
    check("mis_exc1", 32'(bus.misalign_exc), 32'h1);
    check("mis_addr1", bus.misalign_addr, 32'h3002);
    check("mis_pc", bus.pc, 32'h3000);
    check("mis_flush", 32'(bus.flush), 32'h0);
    check("mis_cnt", 32'(bus.redirect_cnt), 32'h2);
    bus.redir_target = 32'h3006;
    step(1);
    check("mis_exc2", 32'(bus.misalign_exc), 32'h1);
    check("mis_addr2", bus.misalign_addr, 32'h3006);
    bus.redir_target  = 32'h300B;
    bus.redir_is_jalr = 1'b1;
    step(1);
    check("mis_exc3", 32'(bus.misalign_exc), 32'h1);
    check("mis_addr3", bus.misalign_addr, 32'h300A);
    bus.redir_valid   = 1'b0;
    bus.redir_is_jalr = 1'b0;
    step(1);
    check("mis_exc_off", 32'(bus.misalign_exc), 32'h0);
    check("mis_addr_hold", bus.misalign_addr, 32'h300A);

    // Valid held across FLUSH with a second target
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h5000;
    step(1);
    bus.redir_target = 32'h4000;
    check("hold_pc0", bus.pc, 32'h5000);
    check("hold_ready0", 32'(bus.redir_ready), 32'h0);
    step(1); check("hold_pc1", bus.pc, 32'h5000);
    step(1); check("hold_pc2", bus.pc, 32'h5000);
    check("hold_ready2", 32'(bus.redir_ready), 32'h1);
    step(1);
    bus.redir_valid = 1'b0;
    check("hold_pc3", bus.pc, 32'h4000);
    check("hold_cnt", 32'(bus.redirect_cnt), 32'h4);
    step(2);

    // Reset during the second flush cycle
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h6000;
    step(1);
    bus.redir_valid = 1'b0;
    check("rf_flush", 32'(bus.flush), 32'h1);
    check("rf_cnt", 32'(bus.redirect_cnt), 32'h5);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rf_pc", bus.pc, 32'h0);
    check("rf_flush_off", 32'(bus.flush), 32'h0);
    check("rf_ready", 32'(bus.redir_ready), 32'h1);
    check("rf_cnt_zero", 32'(bus.redirect_cnt), 32'h0);

    // PC wrap at the top of the address space
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'hFFFF_FFF8;
    step(1);
    bus.redir_valid = 1'b0;
    step(2);
    check("wrap_pc_start", bus.pc, 32'hFFFF_FFF8);
    bus.fetch_ready = 1'b1;
    step(1); check("wrap_pc_top", bus.pc, 32'hFFFF_FFFC);
    step(1); check("wrap_pc_zero", bus.pc, 32'h0);
    bus.fetch_ready = 1'b0;

    // Redirect counter wrap on the narrow instance
    rst8 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (bus8.redirect_cnt == 8'hFF) break;
    end
    check("cnt8_reach_ff", 32'(bus8.redirect_cnt), 32'hFF);
    step(2);
    check("cnt8_wrap", 32'(bus8.redirect_cnt), 32'h0);
    check("cnt8_pc", bus8.pc, 32'h200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
